psum_drain_unit: RTL and testbench
==================================

Name: psum_drain_unit

Overview:
- Drains the partial-sum accumulator at the end of each output tile.
- On `start`, snapshots the parallel `Num_PE*DW` psum vector into a shadow register and pulses `clear_psum` back to the accumulator, so the next tile can begin accumulating immediately.
- Serialises the Num_PE lanes, one word per handshake, to the output feature-map memory or stream, with address generation and optional ReLU.
- Sits between the accumulation stage and the output BRAM writer.

Parameters:
- DW, 14, psum word width (signed two's complement).
- Num_PE, 16, number of PE lanes in the psum vector.
- ADDR_W, 10, output memory address width.
- IDX_W, $clog2(Num_PE), lane index width (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse: accumulation for the tile is complete.
- base_addr  input  ADDR_W  output address of lane 0; sampled with start.
- relu_en  input  1  apply ReLU to drained words; sampled with start.
- psum_in  input  Num_PE*DW  accumulator output; lane k is bits [k*DW +: DW].
- clear_psum  output  1  one-cycle pulse that clears the accumulator.
- out_valid  output  1  out_data/out_addr valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DW  drained psum word.
- out_addr  output  ADDR_W  destination address.
- out_last  output  1  current word is lane Num_PE-1.
- busy  output  1  high in DRAIN and DONE.
- done  output  1  one-cycle pulse after the last word transfers.
- overrun  output  1  one-cycle pulse when start is dropped.

Behaviour:
- **Reset:**
  - All outputs are 0 during and after reset; state=IDLE, idx=0, shadow=0.
  - Reset mid-drain aborts: no done, no clear_psum, remaining words are lost.
- **States:** IDLE, DRAIN, DONE. All outputs are registered or decoded from registered state only; there is no combinational path from psum_in to the outputs.
- **IDLE:**
  - On start at edge T: shadow<=psum_in, base<=base_addr, relu<=relu_en, idx<=0, state<=DRAIN.
  - clear_psum=1 for exactly the cycle after edge T.
  - The accumulator must not be cleared before the capture, so the capture and clear are ordered this way.
- **DRAIN:**
  - out_valid=1.
  - out_data = lane idx of shadow. If relu=1 and the lane MSB=1, out_data=0; otherwise the raw lane.
  - out_addr = (base + idx) mod 2^ADDR_W; wrap-around is silent.
  - out_last = (idx == Num_PE-1).
- **Handshake:**
  - A transfer happens on an edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_addr and out_last hold stable.
  - out_ready is ignored when out_valid=0.
- **Lane advance:**
  - On a transfer with idx<Num_PE-1: idx<=idx+1.
  - On a transfer with idx==Num_PE-1: state<=DONE, out_valid drops the next cycle.
- **DONE (one cycle):**
  - done=1, busy=1.
  - Next state is IDLE, or DRAIN if start=1 in this cycle (captured exactly as in IDLE, with its own clear_psum pulse).
- **Latency:** with out_ready held high, start at edge T gives:
  - first word valid in cycle T+1;
  - last word in cycle T+Num_PE;
  - done in cycle T+Num_PE+1.
- **Start while in DRAIN:** start is ignored. The shadow and the accumulator are untouched, no clear_psum is issued, and overrun pulses for one cycle.
- **Independence from the accumulator:** psum_in changes after capture do not affect drained data.
- **Back-pressure:** there is no timeout. The block waits indefinitely for out_ready.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, DRAIN=2'd1, DONE=2'd2);
  - DW and Num_PE defaults shared with the accumulation unit;
  - the lane-extract convention (lane k at [k*DW +: DW]).
- One natural combinational sub-module, psum_lane_select: shadow vector + idx + relu -> DW word.
- FSM, counter and address generation stay in the top module.

Test Plan:
1. Single drain, no back-pressure.
   - Stimulus: lanes k = k-8 (lane 0=-8 ... lane 15=+7), base_addr=0x100, relu_en=0, out_ready=1, start at T.
   - Required: clear_psum at T+1; words -8..7 at addresses 0x100..0x10F in cycles T+1..T+16; out_last only on 0x10F; done at T+17.
2. ReLU.
   - Stimulus: same vector with relu_en=1.
   - Required: lanes 0..7 output 0, lanes 8..15 output 0..7; the maximum value 14'h1FFF passes unchanged.
3. Back-pressure.
   - Stimulus: out_ready toggles 1,0,0,1,...
   - Required: out_data and out_addr hold through stalls; exactly 16 transfers, in order, with no duplicates; done follows the last transfer.
4. Address wrap.
   - Stimulus: base_addr=0x3FA.
   - Required: addresses 0x3FA..0x3FF, then 0x000..0x009.
5. Overrun and back-to-back.
   - Stimulus: start mid-drain; then start again in the DONE cycle with a new vector.
   - Required: the mid-drain start gives an overrun pulse and no clear_psum, and drained data is unchanged. The start in DONE is accepted, giving a second clear_psum and the new data with no idle gap.
6. Reset mid-drain.
   - Stimulus: rst_n low after 5 transfers, then released.
   - Required: all outputs 0, no done. A fresh start drains all 16 lanes correctly.

Source files
------------

// File: rtl/psum_drain_unit_pkg.sv
// Shared definitions for the psum drain path.
// State codes, default geometry and the lane packing convention.
package psum_drain_unit_pkg;

  localparam int PSUM_DW     = 14;
  localparam int PSUM_NUM_PE = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } drain_state_e;

  // Lane k occupies bits [k*dw +: dw] of a packed psum vector.
  function automatic int lane_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/psum_drain_unit_if.sv
// Drained-word stream towards the output feature-map writer.
// Master drives word/address, slave drives ready.
interface psum_drain_unit_if #(
  parameter int DW     = 14,
  parameter int ADDR_W = 10
);
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_addr, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_addr, out_last,
    output out_ready
  );
endinterface

// File: rtl/psum_drain_unit_lane_select.sv
// Picks one lane out of the shadow vector and applies optional ReLU.
// Purely combinational; fed only from registered state.
module psum_lane_select
  import psum_drain_unit_pkg::*;
#(
  parameter int DW     = PSUM_DW,
  parameter int Num_PE = PSUM_NUM_PE,
  parameter int IDX_W  = (Num_PE > 1) ? $clog2(Num_PE) : 1
) (
  input  logic [Num_PE*DW-1:0] shadow,
  input  logic [IDX_W-1:0]     idx,
  input  logic                 relu,
  output logic [DW-1:0]        word
);

  logic [DW-1:0] lane;

  always_comb begin
    lane = '0;
    for (int k = 0; k < Num_PE; k++) begin
      if (idx == IDX_W'(k)) begin
        lane = shadow[lane_lsb(k, DW) +: DW];
      end
    end
    word = (relu && lane[DW-1]) ? '0 : lane;
  end

endmodule

// File: rtl/psum_drain_unit.sv
// Snapshots the psum vector on start, clears the accumulator and
// streams the lanes out one word per handshake with address generation.
module psum_drain_unit
  import psum_drain_unit_pkg::*;
#(
  parameter int DW     = PSUM_DW,
  parameter int Num_PE = PSUM_NUM_PE,
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 relu_en,
  input  logic [Num_PE*DW-1:0] psum_in,
  output logic                 clear_psum,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  psum_drain_unit_if.master    dout
);

  localparam int IDX_W = (Num_PE > 1) ? $clog2(Num_PE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Num_PE - 1);

  drain_state_e state_q, state_d;

  logic [Num_PE*DW-1:0] shadow_q;
  logic [ADDR_W-1:0]    base_q;
  logic                 relu_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 clear_q;
  logic                 overrun_q;
  logic [DW-1:0]        word;

  logic in_drain;
  logic is_last;
  logic xfer;
  logic capture;

  assign in_drain = (state_q == S_DRAIN);
  assign is_last  = (idx_q == LAST_IDX);
  assign xfer     = in_drain && dout.out_ready;
  // Start is only honoured when no drain is in flight.
  assign capture  = start && !in_drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_DRAIN;
      S_DRAIN: if (xfer && is_last) state_d = S_DONE;
      S_DONE:  state_d = start ? S_DRAIN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      base_q    <= '0;
      relu_q    <= 1'b0;
      idx_q     <= '0;
      clear_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      clear_q   <= capture;
      overrun_q <= start && in_drain;
      if (capture) begin
        shadow_q <= psum_in;
        base_q   <= base_addr;
        relu_q   <= relu_en;
        idx_q    <= '0;
      end else if (xfer && !is_last) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  psum_lane_select #(
    .DW    (DW),
    .Num_PE(Num_PE),
    .IDX_W (IDX_W)
  ) u_sel (
    .shadow(shadow_q),
    .idx   (idx_q),
    .relu  (relu_q),
    .word  (word)
  );

  assign dout.out_valid = in_drain;
  assign dout.out_data  = in_drain ? word : '0;
  assign dout.out_addr  = in_drain ? base_q + ADDR_W'(idx_q) : '0;
  assign dout.out_last  = in_drain && is_last;

  assign clear_psum = clear_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_psum_drain_unit.sv
// Directed bench for psum_drain_unit with an expected-word queue.
// Words are queued at start and checked as the stream delivers them.
module tb_psum_drain_unit;

  localparam int DW  = 14;
  localparam int NPE = 16;
  localparam int AW  = 10;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          l;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic              relu_en;
  logic [NPE*DW-1:0] psum_in;
  logic              clear_psum;
  logic              busy;
  logic              done;
  logic              overrun;

  psum_drain_unit_if #(.DW(DW), .ADDR_W(AW)) o ();

  psum_drain_unit #(.DW(DW), .Num_PE(NPE), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .relu_en   (relu_en),
    .psum_in   (psum_in),
    .clear_psum(clear_psum),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .dout      (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_xfer = 0;
  int   lane_v [NPE];
  exp_t sb [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: pops on each handshake, checks stability on stalls.
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_a;
  exp_t          e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_data", 32'(o.out_data), 32'(hold_d));
        chk("hold_addr", 32'(o.out_addr), 32'(hold_a));
        hold_pend = 1'b0;
      end
      if (o.out_valid && o.out_ready) begin
        n_xfer++;
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'(o.out_addr), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("data", 32'(o.out_data), 32'(e.d));
          chk("addr", 32'(o.out_addr), 32'(e.a));
          chk("last", 32'(o.out_last), 32'(e.l));
        end
      end else if (o.out_valid) begin
        hold_pend = 1'b1;
        hold_d = o.out_data;
        hold_a = o.out_addr;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(o.out_valid), 0);
    chk({tag, "_data"},  32'(o.out_data), 0);
    chk({tag, "_addr"},  32'(o.out_addr), 0);
    chk({tag, "_last"},  32'(o.out_last), 0);
    chk({tag, "_clear"}, 32'(clear_psum), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_ovr"},   32'(overrun), 0);
  endtask

  // Called at posedge+1; returns in cycle T+1 after the capture edge.
  task automatic start_drain(input logic [AW-1:0] base, input logic relu);
    exp_t x;
    int   v;
    start     = 1'b1;
    base_addr = base;
    relu_en   = relu;
    for (int k = 0; k < NPE; k++) begin
      psum_in[k*DW +: DW] = DW'(lane_v[k]);
      v   = (relu && lane_v[k] < 0) ? 0 : lane_v[k];
      x.d = DW'(v);
      x.a = AW'(int'(base) + k);
      x.l = (k == NPE - 1);
      sb.push_back(x);
    end
    n_xfer = 0;
    @(posedge clk); #1;
    start   = 1'b0;
    psum_in = {8{$urandom()}};
    chk("clear_pulse", 32'(clear_psum), 1);
    chk("first_valid", 32'(o.out_valid), 1);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_n_xfer"}, n_xfer, NPE);
  endtask

  task automatic wait_done(input string tag, input bit bp);
    logic pat [4];
    bit   found;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (bp) o.out_ready = pat[c % 4];
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    o.out_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(found), 1);
    end_checks(tag);
  endtask

  initial begin
    bit seen;
    rst_n       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    relu_en     = 1'b0;
    psum_in     = '0;
    o.out_ready = 1'b1;
    #3;
    chk_zero("reset");
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");

    // 1: single drain, latency
    for (int k = 0; k < NPE; k++) lane_v[k] = k - 8;
    @(posedge clk); #1;
    start_drain(10'h100, 1'b0);
    for (int c = 1; c <= NPE; c++) begin
      @(negedge clk);
      chk("t1_valid", 32'(o.out_valid), 1);
      chk("t1_done_early", 32'(done), 0);
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_done", 32'(busy), 1);
    chk("t1_valid_off", 32'(o.out_valid), 0);
    end_checks("t1");
    @(posedge clk); #1;
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_done", 32'(done), 0);

    // 2: ReLU with extremes
    lane_v[0]  = -8192;
    lane_v[15] = 8191;
    start_drain(10'h040, 1'b1);
    wait_done("t2", 1'b0);

    // 3: back-pressure
    for (int k = 0; k < NPE; k++) lane_v[k] = 37 * k - 300;
    @(posedge clk); #1;
    start_drain(10'h200, 1'b0);
    wait_done("t3", 1'b1);

    // 4: address wrap
    for (int k = 0; k < NPE; k++) lane_v[k] = 1000 - 99 * k;
    @(posedge clk); #1;
    start_drain(10'h3FA, 1'b0);
    wait_done("t4", 1'b0);

    // 5: overrun mid-drain, then back-to-back start in DONE
    for (int k = 0; k < NPE; k++) lane_v[k] = 500 * k - 4000;
    @(posedge clk); #1;
    start_drain(10'h080, 1'b0);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 10'h2AA;
    relu_en   = 1'b1;
    psum_in   = {8{32'h1234_5678}};
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_overrun", 32'(overrun), 1);
    chk("t5_no_clear", 32'(clear_psum), 0);
    @(posedge clk); #1;
    chk("t5_overrun_pulse", 32'(overrun), 0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o.out_valid && o.out_last) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_last_seen", 32'(seen), 1);
    @(posedge clk); #1;
    chk("t5_done_cycle", 32'(done), 1);
    end_checks("t5a");
    for (int k = 0; k < NPE; k++) lane_v[k] = 8191 - 1000 * k;
    start_drain(10'h300, 1'b0);
    wait_done("t5b", 1'b0);

    // 6: reset mid-drain, then a fresh full drain
    for (int k = 0; k < NPE; k++) lane_v[k] = 3 * k + 1;
    @(posedge clk); #1;
    start_drain(10'h010, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (n_xfer == 5) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_five_xfers", 32'(seen), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_rst_done", 32'(done), 0);
    end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("t6_after");
    for (int k = 0; k < NPE; k++) lane_v[k] = -5 * k;
    @(posedge clk); #1;
    start_drain(10'h155, 1'b0);
    wait_done("t6", 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
